array_rw_init_ctrl: RTL

//   Request-side controller for a 1R1W synchronous-read SRAM macro (DEPTH x DATA_W).
//   - After reset or on a flush request, sweeps every entry to INIT_VAL.
//   - Arbitrates valid/ready read and write requests onto the macro's R0/W0 ports.
//   - Holds read data stable until the next read, so later writes to the macro

---
 rtl/array_rw_init_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/array_rw_init_ctrl.sv
// Request-side controller for a 1R1W synchronous-read SRAM macro.
// Sweeps the array to INIT_VAL after reset/flush, then forwards read/write requests.
module array_rw_init_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 7,
  parameter int unsigned DEPTH    = 128,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  output logic              io_init_done,
  input  logic              io_r_req_valid,
  output logic              io_r_req_ready,
  input  logic [ADDR_W-1:0] io_r_req_addr,
  output logic              io_r_resp_valid,
  output logic [DATA_W-1:0] io_r_resp_data,
  input  logic              io_w_req_valid,
  output logic              io_w_req_ready,
  input  logic [ADDR_W-1:0] io_w_req_addr,
  input  logic [DATA_W-1:0] io_w_req_data,
  output logic              arr_R0_en,
  output logic [ADDR_W-1:0] arr_R0_addr,
  input  logic [DATA_W-1:0] arr_R0_data,
  output logic              arr_W0_en,
  output logic [ADDR_W-1:0] arr_W0_addr,
  output logic [DATA_W-1:0] arr_W0_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   hold_q;
  logic                rd_fire;
  logic                wr_fire;

  assign io_init_done   = (state_q == ST_IDLE);
  assign io_r_req_ready = io_init_done;
  assign io_w_req_ready = io_init_done;

  // Fires are suppressed while reset is high so nothing reaches the macro.
  assign rd_fire = io_r_req_valid && io_init_done && !reset;
  assign wr_fire = io_w_req_valid && io_init_done && !reset;

  // Response data comes straight from the macro on the response cycle, then from the hold register.
  assign io_r_resp_valid = resp_valid_q;
  assign io_r_resp_data  = resp_valid_q ? arr_R0_data : hold_q;

  assign arr_R0_addr = io_r_req_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      resp_valid_q <= rd_fire;
      if (resp_valid_q) begin
        hold_q <= arr_R0_data;
      end
    end
  end

  // Next-state and macro port steering.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    arr_R0_en   = 1'b0;
    arr_W0_en   = 1'b0;
    arr_W0_addr = io_w_req_addr;
    arr_W0_data = io_w_req_data;

    case (state_q)
      ST_INIT: begin
        arr_W0_en   = !reset;
        arr_W0_addr = init_cnt_q;
        arr_W0_data = INIT_VAL;
        init_cnt_d  = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_IDX) begin
          init_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        arr_R0_en = rd_fire;
        arr_W0_en = wr_fire;
        if (io_flush) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

endmodule
